// File: rtl/ysyx_23060191_ifu_fetch.sv
// Instruction-fetch controller. It owns the architectural PC and keeps at most
// one fetch outstanding on the instruction-memory port. It presents the returned
// word to the IDU over a valid/ready handshake. A redirect replaces the PC at
// once, and any fetch that is still in flight is marked as killed.
module ysyx_23060191_ifu_fetch #(
    parameter int unsigned          CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [CPU_WIDTH-1:0] mem_addr,
    input  logic                 mem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] mem_rsp_data,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic [31:0]          fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic [CPU_WIDTH-1:0] inst_q, inst_d;
    logic [CPU_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                 kill_q, kill_d;
    logic [31:0]          fetch_cnt_q, fetch_cnt_d;

    // Redirect targets are always word aligned, so the low two bits are dropped.
    logic [CPU_WIDTH-1:0] redirect_tgt;
    logic [CPU_WIDTH-1:0] pc_plus4;

    assign redirect_tgt = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
    assign pc_plus4     = pc_q + CPU_WIDTH'(4);

    // State register: every piece of fetch state updates on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            kill_q      <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so that every register samples
            // the values from before the edge, whatever order they are written in.
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            kill_q      <= kill_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Next-state logic. A redirect takes priority over the normal PC update.
    always_comb begin
        // NOTE: every target gets a hold-value default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        kill_d      = kill_q;
        fetch_cnt_d = fetch_cnt_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) pc_d = redirect_tgt;
            end
            REQ: begin
                if (redirect_valid) pc_d = redirect_tgt;
                if (mem_req_ready) begin
                    state_d = WAIT;
                    // The request just accepted carries the old address.
                    kill_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (kill_q || redirect_valid) begin
                        state_d = REQ;
                        if (redirect_valid) pc_d = redirect_tgt;
                    end else begin
                        state_d   = HOLD;
                        inst_d    = mem_rsp_data;
                        inst_pc_d = pc_q;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                    pc_d   = redirect_tgt;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    state_d     = REQ;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    pc_d        = redirect_valid ? redirect_tgt : pc_plus4;
                end else if (redirect_valid) begin
                    // The held instruction is on the wrong path, so drop it.
                    state_d = REQ;
                    pc_d    = redirect_tgt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: both handshake valids are decoded straight from the registered state.
    always_comb begin
        mem_req_valid = (state_q == REQ);
        inst_valid    = (state_q == HOLD);
        mem_addr      = pc_q;
        inst          = inst_q;
        inst_pc       = inst_pc_q;
        fetch_cnt     = fetch_cnt_q;
    end

endmodule

// File: tb/tb_ysyx_23060191_ifu_fetch.sv
// Bench for ysyx_23060191_ifu_fetch. A transaction-level model predicts every
// output on each falling edge. A latency-programmable memory responder serves
// the fetches, and directed scenarios add hand-computed literal expectations.
module tb_ysyx_23060191_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060191_ifu_fetch #(
        .CPU_WIDTH (32),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of instruction memory, as a function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h0000_0413;
        return a ^ 32'h1234_5013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int          rsp_lat = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          wait_left = 0;

    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    end

    always @(negedge clk) begin
        #2;
        mem_rsp_valid = 1'b0;
        if (pend) begin
            if (wait_left == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word(pend_addr);
                pend          = 1'b0;
            end else begin
                wait_left--;
            end
        end
        // A request is accepted at the coming rising edge.
        if (rst_n && mem_req_valid && mem_req_ready) begin
            pend      = 1'b1;
            pend_addr = mem_addr;
            wait_left = rsp_lat;
        end
    end

    // ---------------- transaction-level model ----------------
    // started: the reset bubble is over. busy: a fetch is outstanding.
    // stale: the outstanding fetch is from the wrong path. have: an instruction is offered.
    logic        m_started, m_busy, m_stale, m_have;
    logic [31:0] m_pc, m_inst, m_inst_pc, m_cnt;
    logic [31:0] m_tgt;

    assign m_tgt = redirect_pc & ~32'h3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_busy    <= 1'b0;
            m_stale   <= 1'b0;
            m_have    <= 1'b0;
            m_pc      <= RST_PC;
            m_inst    <= '0;
            m_inst_pc <= '0;
            m_cnt     <= '0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            if (redirect_valid) m_pc <= m_tgt;
        end else if (m_have) begin
            if (inst_ready) begin
                m_cnt  <= m_cnt + 32'd1;
                m_have <= 1'b0;
                m_pc   <= redirect_valid ? m_tgt : m_pc + 32'd4;
            end else if (redirect_valid) begin
                m_have <= 1'b0;
                m_pc   <= m_tgt;
            end
        end else if (m_busy) begin
            if (mem_rsp_valid) begin
                m_busy  <= 1'b0;
                m_stale <= 1'b0;
                if (m_stale || redirect_valid) begin
                    if (redirect_valid) m_pc <= m_tgt;
                end else begin
                    m_have    <= 1'b1;
                    m_inst    <= mem_rsp_data;
                    m_inst_pc <= m_pc;
                end
            end else if (redirect_valid) begin
                m_stale <= 1'b1;
                m_pc    <= m_tgt;
            end
        end else begin
            if (mem_req_ready) begin
                m_busy  <= 1'b1;
                m_stale <= redirect_valid;
            end
            if (redirect_valid) m_pc <= m_tgt;
        end
    end

    // Every falling edge out of reset, compare the DUT with the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mdl_req_valid", 32'(mem_req_valid), 32'(m_started && !m_busy && !m_have));
            check("mdl_inst_valid", 32'(inst_valid), 32'(m_have));
            check("mdl_mem_addr", mem_addr, m_pc);
            check("mdl_inst", inst, m_inst);
            check("mdl_inst_pc", inst_pc, m_inst_pc);
            check("mdl_fetch_cnt", fetch_cnt, m_cnt);
            if (m_have) check("mdl_inst_matches_mem", inst, mem_word(inst_pc));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_req_valid) seen = 1'b1;
        end
        #1;
        check({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_inst(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (inst_valid) seen = 1'b1;
        end
        #1;
        check({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        mem_req_ready  = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        tick();

        // Values held during reset.
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h8000_0000);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_fetch_cnt", fetch_cnt, 32'd0);

        // Basic fetch with memory and IDU both always ready.
        rst_n         = 1'b1;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        rsp_lat       = 0;
        wait_req("t1_req");
        check("t1_addr", mem_addr, 32'h8000_0000);
        wait_inst("t1_inst");
        check("t1_inst_word", inst, 32'h0000_0413);
        check("t1_inst_pc", inst_pc, 32'h8000_0000);
        tick();
        check("t1_next_req", 32'(mem_req_valid), 32'd1);
        check("t1_next_addr", mem_addr, 32'h8000_0004);
        check("t1_cnt", fetch_cnt, 32'd1);

        // Backpressure from the IDU.
        inst_ready = 1'b0;
        wait_inst("t2_inst");
        check("t2_inst_word", inst, 32'h9234_5017);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_hold_valid", 32'(inst_valid), 32'd1);
            check("t2_hold_noreq", 32'(mem_req_valid), 32'd0);
            check("t2_hold_inst", inst, 32'h9234_5017);
            check("t2_hold_pc", inst_pc, 32'h8000_0004);
            check("t2_hold_addr", mem_addr, 32'h8000_0004);
        end
        inst_ready = 1'b1;
        tick();
        check("t2_cnt", fetch_cnt, 32'd2);
        check("t2_next_addr", mem_addr, 32'h8000_0008);

        // Memory backpressure on the request channel.
        mem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_req_held", 32'(mem_req_valid), 32'd1);
            check("t3_addr_held", mem_addr, 32'h8000_0008);
        end
        mem_req_ready = 1'b1;
        tick();
        check("t3_wait_noreq", 32'(mem_req_valid), 32'd0);
        wait_inst("t3_inst");
        check("t3_inst_pc", inst_pc, 32'h8000_0008);
        check("t3_inst_word", inst, 32'h9234_501B);
        rsp_lat = 2;

        // Redirect while a fetch is outstanding.
        wait_req("t4_req");
        check("t4_addr", mem_addr, 32'h8000_000C);
        tick();
        check("t4_in_wait", 32'(mem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1002;
        tick();
        redirect_valid = 1'b0;
        check("t4_aligned_pc", mem_addr, 32'h8000_1000);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                tick();
                check("t4_stale_dropped", 32'(inst_valid), 32'd0);
                if (mem_req_valid) seen = 1'b1;
            end
            check("t4_refetch_seen", 32'(seen), 32'd1);
        end
        check("t4_refetch_addr", mem_addr, 32'h8000_1000);
        rsp_lat = 0;
        wait_inst("t4_inst");
        check("t4_inst_pc", inst_pc, 32'h8000_1000);
        check("t4_inst_word", inst, 32'h9234_4013);
        check("t4_cnt", fetch_cnt, 32'd3);

        // Redirect in HOLD while the IDU accepts in the same cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        check("t5_cnt", fetch_cnt, 32'd4);
        check("t5_req", 32'(mem_req_valid), 32'd1);
        check("t5_addr", mem_addr, 32'h8000_0100);

        // Redirect in REQ while the memory accepts the old address, then PC wrap.
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check("t6_wait", 32'(mem_req_valid), 32'd0);
        check("t6_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        check("t6_stale_dropped", 32'(inst_valid), 32'd0);
        check("t6_refetch", 32'(mem_req_valid), 32'd1);
        wait_inst("t6_inst");
        check("t6_inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("t6_inst_word", inst, 32'hEDCB_AFEF);
        rsp_lat = 3;
        tick();
        check("t6_wrap_addr", mem_addr, 32'h0000_0000);
        check("t6_cnt", fetch_cnt, 32'd5);

        // Asynchronous reset asserted while a fetch is outstanding.
        tick();
        check("t7_in_wait", 32'(mem_req_valid), 32'd0);
        #2;
        rst_n         = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        check("t7_async_addr", mem_addr, 32'h8000_0000);
        check("t7_async_cnt", fetch_cnt, 32'd0);
        check("t7_async_inst", inst, 32'd0);
        check("t7_async_inst_pc", inst_pc, 32'd0);
        check("t7_async_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_req_after_rst", 32'(mem_req_valid), 32'd1);
        tick();
        tick();
        check("t7_late_rsp_ignored", 32'(inst_valid), 32'd0);
        check("t7_still_req", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        rsp_lat       = 0;
        wait_inst("t7_inst");
        check("t7_inst_word", inst, 32'h0000_0413);
        check("t7_inst_pc", inst_pc, 32'h8000_0000);
        tick();
        check("t7_cnt", fetch_cnt, 32'd1);
        check("t7_next_addr", mem_addr, 32'h8000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_ifu_fetch.md
Name: ysyx_23060191_ifu_fetch

Overview:
Instruction-fetch controller sitting directly upstream of the instruction-memory read port and downstream-feeding the IDU. It owns the architectural PC and issues one word-aligned fetch request at a time over a valid/ready request channel. It captures the returned instruction word and presents it to the decoder over a valid/ready handshake. It also supports PC redirect from branch/jump resolution, discarding stale in-flight fetches.

Parameters:
CPU_WIDTH, 32, datapath/address width
RESET_PC, 32'h8000_0000, PC value loaded at reset

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request this cycle
mem_addr  output  CPU_WIDTH  fetch address (= current PC)
mem_rsp_valid  input  1  instruction word returned this cycle
mem_rsp_data  input  CPU_WIDTH  returned instruction word
inst_valid  output  1  instruction available to IDU
inst_ready  input  1  IDU accepts instruction
inst  output  CPU_WIDTH  instruction word to IDU
inst_pc  output  CPU_WIDTH  PC of presented instruction
redirect_valid  input  1  load new PC (branch/jump/trap)
redirect_pc  input  CPU_WIDTH  redirect target
fetch_cnt  output  32  count of instructions delivered to IDU

Behaviour:
- Reset (rst_n low, async): state=IDLE, pc=RESET_PC, kill=0, mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, fetch_cnt=0. mem_addr always drives pc.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: first cycle after reset release; unconditionally -> REQ. Redirect in IDLE loads pc, still -> REQ.
- REQ: mem_req_valid=1, mem_addr=pc. On mem_req_ready -> WAIT. mem_addr stable until accepted.
- WAIT: mem_req_valid=0. On mem_rsp_valid:
  - kill=0: inst<=mem_rsp_data, inst_pc<=pc, -> HOLD.
  - kill=1: discard data, clear kill, -> REQ.
  - mem_rsp_valid is ignored outside WAIT.
- HOLD: inst_valid=1. inst and inst_pc are stable while inst_valid && !inst_ready. On inst_ready: pc<=pc+4 (mod 2^CPU_WIDTH, wraps 0xFFFF_FFFC -> 0), fetch_cnt<=fetch_cnt+1 (wraps), -> REQ.
- inst_valid is a registered flag, high exactly in HOLD. mem_req_valid is high exactly in REQ.
- Minimum latency: request accepted at cycle N, response at N+1, inst_valid at N+2. With ready always high, throughput is one instruction per 3 cycles.
- Redirect (redirect_valid=1) has priority over normal PC update in every state. Target is pc<=redirect_pc with bits[1:0] forced to 0.
  - REQ, request not accepted: new pc is used from the next cycle, stay REQ.
  - REQ with mem_req_ready the same cycle: the old-address request is in flight. Go WAIT with kill=1.
  - WAIT: set kill=1. If mem_rsp_valid arrives the same cycle, discard it and -> REQ with kill=0.
  - HOLD: inst_valid drops next cycle, -> REQ, no pc+4.
    - If inst_ready is high the same cycle, the handshake completes: fetch_cnt increments, but pc takes redirect_pc.
- Only one outstanding request at any time; no request is issued in WAIT or HOLD.
- Reset asserted mid-fetch: all state returns to reset values immediately. Any later memory response is ignored because the FSM is not in WAIT.

Test Plan:
- Reset release, mem_req_ready=1, mem returns 0x00000413 one cycle after accept, inst_ready=1 -> mem_addr=0x80000000, then inst_valid with inst=0x00000413, inst_pc=0x80000000, next mem_addr=0x80000004, fetch_cnt=1.
- IDU backpressure: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc unchanged, no mem_req_valid, pc not incremented. Then ready=1 -> fetch_cnt+1, next request at pc+4.
- mem_req_ready held low 4 cycles -> mem_req_valid stays 1 with constant mem_addr. Accepted on cycle 5 -> WAIT.
- Redirect in WAIT to 0x80001002 -> stale response discarded (inst_valid stays 0). Next mem_addr=0x80001000, and its response is delivered with inst_pc=0x80001000.
- Redirect in HOLD with inst_ready=1 the same cycle, target 0x80000100 -> fetch_cnt increments, next mem_addr=0x80000100 (not pc+4).
- pc=0xFFFFFFFC delivered and accepted -> next mem_addr=0x00000000. Async reset asserted in WAIT -> outputs return to reset values without a clock edge.
